aes_seq_ctrl: RTL and testbench

Sequencer for the low-area byte-serial AES-128 encryption core. It launches the key and plaintext parallel-to-serial loaders, waits for each to finish, and then steps the shared byte datapath through the schedule. The schedule is the initial AddRoundKey, then 10 rounds of key-expansion, SubBytes/ShiftRows, MixColumns and AddRoundKey. It drives the per-byte enables, the byte/column index and the round number, and flags valid ciphertext bytes and completion. It sits between the top-level start/done handshake and the datapath plus its `pts_key`-style loaders.

---
 rtl/aes_seq_ctrl.sv | 106 ++++++++++
 tb/tb_aes_seq_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/aes_seq_ctrl.sv
// rtl/aes_seq_ctrl.sv - byte-serial AES-128 schedule sequencer
module aes_seq_ctrl #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       key_ready,
  input  logic       pt_ready,
  output logic       key_start,
  output logic       pt_start,
  output logic       ark_en,
  output logic       ks_en,
  output logic       sb_en,
  output logic       mc_en,
  output logic [3:0] byte_idx,
  output logic [3:0] round,
  output logic       out_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDK  = 3'd1,
    LDP  = 3'd2,
    ARK  = 3'd3,
    KS   = 3'd4,
    SB   = 3'd5,
    MC   = 3'd6,
    DONE = 3'd7
  } state_t;

  localparam logic [3:0] NR_L = 4'(NR);

  state_t     state, state_nxt;
  logic [3:0] round_nxt, byte_idx_nxt;
  logic       ld_first, ld_first_nxt;
  logic       counting;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      round    <= 4'd0;
      byte_idx <= 4'd0;
      ld_first <= 1'b0;
    end else begin
      state    <= state_nxt;
      round    <= round_nxt;
      byte_idx <= byte_idx_nxt;
      ld_first <= ld_first_nxt;
    end
  end

  // ld_first marks the launch-pulse cycle of LDK/LDP; ready is ignored there
  always_comb begin
    state_nxt    = state;
    round_nxt    = round;
    ld_first_nxt = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt    = LDK;
        round_nxt    = 4'd0;
        ld_first_nxt = 1'b1;
      end
      LDK: if (!ld_first && key_ready) begin
        state_nxt    = LDP;
        ld_first_nxt = 1'b1;
      end
      LDP: if (!ld_first && pt_ready) state_nxt = ARK;
      ARK: if (byte_idx == 4'd15) begin
        if (round == NR_L) begin
          state_nxt = DONE;
        end else begin
          state_nxt = KS;
          round_nxt = round + 4'd1;
        end
      end
      KS: if (byte_idx == 4'd3) state_nxt = SB;
      SB: if (byte_idx == 4'd15) state_nxt = (round < NR_L) ? MC : ARK;
      MC: if (byte_idx == 4'd3) state_nxt = ARK;
      DONE: begin
        state_nxt = IDLE;
        round_nxt = 4'd0;
      end
      default: begin
        state_nxt = IDLE;
        round_nxt = 4'd0;
      end
    endcase
  end

  assign counting     = (state == ARK) || (state == KS) || (state == SB) || (state == MC);
  assign byte_idx_nxt = (counting && state_nxt == state) ? byte_idx + 4'd1 : 4'd0;

  assign key_start = (state == LDK) && ld_first;
  assign pt_start  = (state == LDP) && ld_first;
  assign ark_en    = (state == ARK);
  assign ks_en     = (state == KS);
  assign sb_en     = (state == SB);
  assign mc_en     = (state == MC);
  assign out_valid = (state == ARK) && (round == NR_L);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// tb/tb_aes_seq_ctrl.sv - directed self-checking bench for aes_seq_ctrl
module tb_aes_seq_ctrl;

  logic       clk, rst, start, key_ready, pt_ready;
  logic       key_start, pt_start, ark_en, ks_en, sb_en, mc_en;
  logic [3:0] byte_idx, round;
  logic       out_valid, busy, done;
  logic [16:0] outs;

  int tests = 0;
  int fails = 0;

  int mc_tot = 0, ks_tot = 0, sb_tot = 0, ark_tot = 0, multi_tot = 0, r10_tot = 0;
  int kst_tot = 0, pst_tot = 0, done_tot = 0, ov_tot = 0, ov_err = 0;

  aes_seq_ctrl #(.NR(10)) dut (
    .clk(clk), .rst(rst), .start(start), .key_ready(key_ready), .pt_ready(pt_ready),
    .key_start(key_start), .pt_start(pt_start), .ark_en(ark_en), .ks_en(ks_en),
    .sb_en(sb_en), .mc_en(mc_en), .byte_idx(byte_idx), .round(round),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  assign outs = {key_start, pt_start, ark_en, ks_en, sb_en, mc_en, out_valid, busy, done,
                 byte_idx, round};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mc_en) mc_tot <= mc_tot + 1;
    if (ks_en) ks_tot <= ks_tot + 1;
    if (sb_en) sb_tot <= sb_tot + 1;
    if (ark_en) ark_tot <= ark_tot + 1;
    if ((int'(ark_en) + int'(ks_en) + int'(sb_en) + int'(mc_en)) > 1) multi_tot <= multi_tot + 1;
    if (mc_en && round == 4'd10) r10_tot <= r10_tot + 1;
    if (key_start) kst_tot <= kst_tot + 1;
    if (pt_start) pst_tot <= pst_tot + 1;
    if (done) done_tot <= done_tot + 1;
    if (out_valid) begin
      ov_tot <= ov_tot + 1;
      if (byte_idx != 4'(ov_tot) || round != 4'd10 || !ark_en) ov_err <= ov_err + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_enc(input int abort_at, input bit poke);
    int n, ov_first, rstep_err;
    int b_mc, b_ks, b_sb, b_ark, b_multi, b_r10, b_kst, b_pst, b_done, b_ov, b_ove;
    logic [3:0] prev;
    bit poked;
    b_mc = mc_tot; b_ks = ks_tot; b_sb = sb_tot; b_ark = ark_tot; b_multi = multi_tot;
    b_r10 = r10_tot; b_kst = kst_tot; b_pst = pst_tot; b_done = done_tot;
    b_ov = ov_tot; b_ove = ov_err;
    poked = 0; ov_first = 0; rstep_err = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("key_start_pulse", key_start, 1);
    check("busy_ldk", busy, 1);
    repeat (16) @(negedge clk);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    check("pt_start_pulse", pt_start, 1);
    repeat (16) @(negedge clk);
    pt_ready = 1'b1;
    @(negedge clk);
    pt_ready = 1'b0;
    n = 1;
    check("ark0_entry", {ark_en, round, byte_idx}, {1'b1, 4'd0, 4'd0});
    prev = round;
    while (!done && n < 600) begin
      if (n == abort_at) begin
        check("abort_point", {sb_en, round}, {1'b1, 4'd10});
        #2 rst = 1'b0;
        #1 check("abort_outs_zero", outs, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_tot - b_done, 0);
        check("abort_no_ov", ov_tot - b_ov, 0);
        check("abort_idle", busy, 0);
        return;
      end
      start = 1'b0;
      if (poke && !poked && round == 4'd5) begin
        start = 1'b1;
        poked = 1;
      end
      @(negedge clk);
      n++;
      if (round != prev && round != prev + 4'd1) rstep_err++;
      prev = round;
      if (out_valid && ov_first == 0) ov_first = n;
    end
    start = 1'b0;
    check("done_latency", n, 413);
    check("round_at_done", round, 10);
    check("round_steps", rstep_err, 0);
    check("ov_first_cycle", ov_first, 397);
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_done", busy, 0);
    check("no_restart", key_start, 0);
    @(negedge clk);
    check("no_restart2", key_start, 0);
    check("mc_total", mc_tot - b_mc, 36);
    check("ks_total", ks_tot - b_ks, 40);
    check("sb_total", sb_tot - b_sb, 160);
    check("ark_total", ark_tot - b_ark, 176);
    check("multi_enable", multi_tot - b_multi, 0);
    check("mc_round10", r10_tot - b_r10, 0);
    check("key_start_count", kst_tot - b_kst, 1);
    check("pt_start_count", pst_tot - b_pst, 1);
    check("done_count", done_tot - b_done, 1);
    check("ov_count", ov_tot - b_ov, 16);
    check("ov_order", ov_err - b_ove, 0);
  endtask

  initial begin
    int err;
    rst = 1'b0; start = 1'b0; key_ready = 1'b0; pt_ready = 1'b0;
    #2 check("reset_outs", outs, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_outs", outs, 0);

    run_enc(0, 1'b0);
    run_enc(0, 1'b1);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("kst_abort_pulse", key_start, 1);
    #2 rst = 1'b0;
    #1 check("kst_abort_outs", outs, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("kst_abort_idle", busy, 0);

    run_enc(385, 1'b0);
    run_enc(0, 1'b0);

    rst = 1'b0;
    key_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("kr_held_pulse", {key_start, pt_start}, 2'b10);
    @(negedge clk);
    check("kr_held_ldk2", {key_start, pt_start, busy}, 3'b001);
    @(negedge clk);
    check("kr_held_ldp", pt_start, 1);
    err = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy || ark_en || pt_start || key_start) err++;
    end
    check("ldp_hold", err, 0);
    rst = 1'b0;
    key_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("final_idle", outs, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
